// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM capture pin inputs and measurement results bundle
interface pwm_capture_if #(
  parameter int PERIOD_W = 10
);
  logic                tick_in;
  logic                pwm_in;
  logic [7:0]          duty_out;
  logic [PERIOD_W-1:0] period_out;
  logic                valid_out;
  logic                lost_out;

  modport master (
    output tick_in, pwm_in,
    input  duty_out, period_out, valid_out, lost_out
  );

  modport slave (
    input  tick_in, pwm_in,
    output duty_out, period_out, valid_out, lost_out
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - servo PWM duty/period capture with loss-of-signal detection
// Optional glitch filter on the synchronized input: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int PERIOD_W = 10,
  parameter int TIMEOUT  = 512
) (
  input  logic         clock,
  input  logic         reset,
  pwm_capture_if.slave bus
);
  localparam int                  DW      = (PERIOD_W > 8) ? PERIOD_W : 8;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] TO_LIM  = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              r_state, w_state;
  logic                r_sync1, r_sync2, r_lvl_d;
  logic                r_rise, r_fall;
  logic                w_s_lvl;
  logic [PERIOD_W-1:0] r_hi, r_lo, r_to;
  logic [PERIOD_W-1:0] w_hi, w_lo, w_to;
  logic [7:0]          r_duty, w_duty;
  logic [PERIOD_W-1:0] r_period, w_period;
  logic                r_valid, w_valid;
  logic                r_lost, w_lost;
  logic [PERIOD_W-1:0] w_lo_cnt;
  logic [PERIOD_W:0]   w_sum;
  logic [DW-1:0]       w_hi_ext;
  logic                w_edge;

  // Input path runs through reset so a line already high is not taken as a new rise.
  always_ff @(posedge clock) begin
    r_sync1 <= bus.pwm_in;
    r_sync2 <= r_sync1;
    r_lvl_d <= w_s_lvl;
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [2:0] r_hist;
  logic       w_all_hi, w_all_lo;

  always_ff @(posedge clock) begin
    r_hist <= {r_hist[1:0], r_sync2};
  end

  assign w_all_hi = r_sync2 & (&r_hist);
  assign w_all_lo = ~r_sync2 & ~(|r_hist);
  assign w_s_lvl  = w_all_hi ? 1'b1 : (w_all_lo ? 1'b0 : r_lvl_d);
`else
  assign w_s_lvl = r_sync2;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_s_lvl & ~r_lvl_d;
      r_fall <= ~w_s_lvl & r_lvl_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_to     <= '0;
      r_duty   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_lost   <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
      r_to     <= w_to;
      r_duty   <= w_duty;
      r_period <= w_period;
      r_valid  <= w_valid;
      r_lost   <= w_lost;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_to     = bus.tick_in ? r_to + 1'b1 : r_to;
    w_duty   = r_duty;
    w_period = r_period;
    w_valid  = 1'b0;
    w_lost   = r_lost;
    w_edge   = 1'b0;

    // The closing low tick is folded in before the period is summed.
    w_lo_cnt = (bus.tick_in && (r_lo != CNT_MAX)) ? r_lo + 1'b1 : r_lo;
    w_sum    = {1'b0, r_hi} + {1'b0, w_lo_cnt};
    w_hi_ext = DW'(r_hi);

    case (r_state)
      IDLE: begin
        if (r_rise) begin
          w_hi    = '0;
          w_lo    = '0;
          w_to    = '0;
          w_edge  = 1'b1;
          w_state = HIGH;
        end
      end
      HIGH: begin
        if (bus.tick_in && (r_hi != CNT_MAX)) w_hi = r_hi + 1'b1;
        if (r_fall) begin
          w_to    = '0;
          w_edge  = 1'b1;
          w_state = LOW;
        end
      end
      LOW: begin
        w_lo = w_lo_cnt;
        if (r_rise) begin
          w_duty   = (w_hi_ext > DW'(255)) ? 8'hFF : w_hi_ext[7:0];
          w_period = w_sum[PERIOD_W] ? CNT_MAX : w_sum[PERIOD_W-1:0];
          w_valid  = 1'b1;
          w_lost   = 1'b0;
          w_hi     = '0;
          w_lo     = '0;
          w_to     = '0;
          w_edge   = 1'b1;
          w_state  = HIGH;
        end
      end
      default: w_state = IDLE;
    endcase

    // A stuck line decodes to its level; re-announcing the same loss is suppressed.
    if (!w_edge && (r_to == TO_LIM)) begin
      w_state  = IDLE;
      w_to     = '0;
      w_lost   = 1'b1;
      w_duty   = w_s_lvl ? 8'hFF : 8'h00;
      w_period = '0;
      w_valid  = !r_lost || (w_duty != r_duty);
    end
  end

  assign bus.duty_out   = r_duty;
  assign bus.period_out = r_period;
  assign bus.valid_out  = r_valid;
  assign bus.lost_out   = r_lost;
endmodule
